shift_pipe: RTL
===============

// Module: shift_pipe
// PURPOSE
//  Parametrised pipelined barrel shifter for the ALU datapath. Supports SLL, SRL, SRA and ROR
//  on a WIDTH-bit operand with a runtime shift amount. One shift-amount bit is resolved per stage,
//  so the pipeline has log2(WIDTH) stages, a valid/ready handshake and full-throughput backpressure.
// PARAMETERS
//  WIDTH  32             operand/result width; power of two, >= 4
//  SHW    $clog2(WIDTH)  shift-amount width = pipeline depth (derived, not overridden)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous active-high reset
//  in_valid   in   1      input operation valid
//  in_ready   out  1      shifter can accept this cycle
//  in_a       in   WIDTH  operand
//  in_shamt   in   SHW    shift amount, 0..WIDTH-1
//  in_op      in   2      00=SLL 01=SRL 10=SRA 11=ROR
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  out_res    out  WIDTH  shifted result
//  out_zero   out  1      out_res == 0
//  busy       out  1      any stage holds a valid op
// BEHAVIOUR
//  - Pipeline has stage registers S0..S(SHW-1). Each stage holds valid, data, remaining shamt and op.
//  - Stage k applies a shift of 2^k when shamt bit k is 1, and passes the data through otherwise.
//  - SLL and SRL fill with 0. SRA fills with the sign bit of the original operand.
//  - ROR wraps the bits shifted out of bit 0 back into bit WIDTH-1.
//  - Global advance: adv = !out_valid | out_ready. in_ready = adv (combinational).
//  - On adv, every stage loads from its predecessor. S0 loads the input and its valid = in_valid.
//  - When adv=0, all stages hold and their contents do not change.
//  - Input is accepted on in_valid & in_ready; a transfer completes on out_valid & out_ready.
//  - Latency is SHW cycles from acceptance to out_valid, with no stall: 5 for WIDTH=32.
//    Throughput is 1 op/cycle.
//  - out_res, out_zero and out_valid come from the last stage register (all registered).
//    out_zero is computed in the last stage.
//  - Order is preserved; no op is dropped or duplicated.
//  - Accept and drain in the same cycle is legal when out_ready=1. Occupancy is then unchanged.
//  - Backpressure: while out_valid=1 and out_ready=0, out_res, out_zero and out_valid stay
//    stable and in_ready=0.
//  - shamt=0: the result equals in_a for every op.
//  - busy = OR of all stage valids.
//  - Reset, asynchronous, any time including mid-flight:
//    - All stage valids clear, so out_valid=0 and busy=0; in-flight ops are discarded.
//    - out_res=0 and out_zero=1; data registers clear to 0.
//  - In the first cycle after reset deassertion, in_ready=1.
//  - Bubbles (in_valid=0 on adv) propagate as invalid stages and never produce out_valid.
// TESTING
//  1. WIDTH=32, a=32'h8000_00F0:
//     - SLL 4 -> 32'h0000_0F00
//     - SRL 4 -> 32'h0800_000F
//     - SRA 4 -> 32'hF800_000F
//     - ROR 4 -> 32'h0800_000F
//     - Each appears exactly 5 cycles after acceptance.
//  2. Edges:
//     - shamt=0, a=32'hDEAD_BEEF, all four ops -> 32'hDEAD_BEEF
//     - shamt=31, a=32'h8000_0000: SRA -> 32'hFFFF_FFFF, SRL -> 32'h1
//     - SRL 1 of 32'h1 -> 0 with out_zero=1
//  3. Streaming: out_ready=1, 16 back-to-back random ops.
//     - Results come out in order, one per cycle, after 5 cycles.
//     - Each matches the reference model.
//  4. Backpressure: fill the pipe, then hold out_ready=0 for 7 cycles.
//     - in_ready=0 and out_res is unchanged throughout.
//     - After release, the remaining results drain with no loss or duplication.
//  5. Reset mid-flight: assert rst with 3 ops in flight.
//     - out_valid=0 and busy=0 immediately (asynchronous).
//     - No stale result emerges after release; a new op returns correctly after 5 cycles.
//  6. Parameter sweep: WIDTH=8 (latency 3) and WIDTH=64 (latency 6) with random ops
//     -> results match the model.

Source files
------------

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) for the ALU datapath.
// Stage k resolves shift-amount bit k, so a WIDTH-bit operand passes through
// log2(WIDTH) registered stages. One op per cycle, with global-stall backpressure.
//
// Handshake: a beat is accepted on in_valid & in_ready and delivered on
// out_valid & out_ready. in_ready is high whenever the pipe can advance
// (output empty or being drained this cycle), so accept and drain may happen
// in the same cycle. Producers must hold in_valid/in_a/in_shamt/in_op stable
// until accepted; out_* stay stable while out_valid=1 and out_ready=0.
module shift_pipe #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_zero,
    output logic             busy
);

    // Fixed-distance shift used by one stage; op: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
    // SRA keeps the sign: every stage shifts arithmetically, so the MSB of the
    // original operand is preserved all the way down the pipe.
    function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] d,
                                                     input logic [1:0]       op,
                                                     input int               amt);
        logic [WIDTH-1:0] r;
        case (op)
            2'b00:   r = d << amt;
            2'b01:   r = d >> amt;
            2'b10:   r = $signed(d) >>> amt;
            default: r = (d >> amt) | (d << (WIDTH - amt));
        endcase
        return r;
    endfunction

    logic                 adv;

    // Stage registers. The last stage does not need shift amount or op.
    logic [SHW-1:0]       valid_q;
    logic [WIDTH-1:0]     data_q  [SHW];
    logic [SHW-1:0]       rem_q   [SHW-1];
    logic [1:0]           op_q    [SHW-1];
    logic                 zero_q;

    // Inputs seen by each stage (stage 0 sees the module inputs).
    logic [SHW-1:0]       st_valid;
    logic [WIDTH-1:0]     st_data [SHW];
    logic [SHW-1:0]       st_rem  [SHW];
    logic [1:0]           st_op   [SHW];
    logic [WIDTH-1:0]     shifted [SHW];

    // The whole pipe moves together; it stalls only when a result is waiting.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Remaining shift amount is carried right-shifted, so bit 0 is always
    // the bit this stage resolves.
    for (genvar k = 0; k < SHW; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign st_valid[0] = in_valid;
            assign st_data[0]  = in_a;
            assign st_rem[0]   = in_shamt;
            assign st_op[0]    = in_op;
        end else begin : g_next
            assign st_valid[k] = valid_q[k-1];
            assign st_data[k]  = data_q[k-1];
            assign st_rem[k]   = rem_q[k-1];
            assign st_op[k]    = op_q[k-1];
        end
        assign shifted[k] = st_rem[k][0] ? stage_shift(st_data[k], st_op[k], 1 << k)
                                         : st_data[k];
    end

    // Pipeline advance: every stage loads its predecessor on adv, else all hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < SHW; k++) begin
                data_q[k] <= '0;
            end
            for (int k = 0; k < SHW - 1; k++) begin
                rem_q[k] <= '0;
                op_q[k]  <= '0;
            end
        end else if (adv) begin
            valid_q <= st_valid;
            for (int k = 0; k < SHW; k++) begin
                data_q[k] <= shifted[k];
            end
            for (int k = 0; k < SHW - 1; k++) begin
                rem_q[k] <= st_rem[k] >> 1;
                op_q[k]  <= st_op[k];
            end
        end
    end

    // Zero flag registered alongside the last stage so out_zero is glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b1;
        end else if (adv) begin
            zero_q <= (shifted[SHW-1] == '0);
        end
    end

    assign out_valid = valid_q[SHW-1];
    assign out_res   = data_q[SHW-1];
    assign out_zero  = zero_q;
    assign busy      = |valid_q;

endmodule
